// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls words from a show-ahead FIFO and serialises them
// LSB first with one start bit and SB stop bits, DVSR clocks per bit.
module fifo_uart_tx #(
    parameter int B    = 8,
    parameter int DVSR = 16,
    parameter int SB   = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         empty,
    input  logic [B-1:0] r_data,
    output logic         rd,
    output logic         tx,
    output logic         tx_busy,
    output logic         tx_done
);

    localparam int TW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int NW = (B > 1) ? $clog2(B) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DVSR - 1);
    localparam logic [NW-1:0] BIT_LAST  = NW'(B - 1);
    localparam logic [NW-1:0] STOP_LAST = NW'(SB - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        r_state, w_state_next;
    logic [TW-1:0] r_tick, w_tick_next;
    logic [NW-1:0] r_nbit, w_nbit_next;
    logic [B-1:0]  r_shift, w_shift_next;
    logic          r_tx, w_tx_next;
    logic          w_tick_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_nbit  <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_tick  <= w_tick_next;
            r_nbit  <= w_nbit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

    // The bit counter is reused to count stop bits once the data bits are out.
    always_comb begin
        w_tick_end   = (r_tick == TICK_LAST);
        w_state_next = r_state;
        w_tick_next  = r_tick + TW'(1);
        w_nbit_next  = r_nbit;
        w_shift_next = r_shift;
        case (r_state)
            IDLE: begin
                w_tick_next = '0;
                if (!empty) begin
                    w_state_next = START;
                    w_shift_next = r_data;
                end
            end
            START: begin
                if (w_tick_end) begin
                    w_state_next = DATA;
                    w_tick_next  = '0;
                    w_nbit_next  = '0;
                end
            end
            DATA: begin
                if (w_tick_end) begin
                    w_tick_next  = '0;
                    w_shift_next = r_shift >> 1;
                    if (r_nbit == BIT_LAST) begin
                        w_state_next = STOP;
                        w_nbit_next  = '0;
                    end else begin
                        w_nbit_next = r_nbit + NW'(1);
                    end
                end
            end
            STOP: begin
                if (w_tick_end) begin
                    w_tick_next = '0;
                    if (r_nbit == STOP_LAST) begin
                        w_state_next = IDLE;
                        w_nbit_next  = '0;
                    end else begin
                        w_nbit_next = r_nbit + NW'(1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_tick_next  = '0;
            end
        endcase
        // The line is registered, so it follows the state we are about to enter.
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_comb begin
        rd      = (r_state == IDLE) & ~empty & reset;
        tx      = r_tx;
        tx_busy = (r_state != IDLE);
        tx_done = (r_state == STOP) & w_tick_end & (r_nbit == STOP_LAST);
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a queue models the FIFO, outputs are logged
// per cycle at the falling edge and compared against hand-derived frames.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       empty_a, empty_b;
    logic [7:0] data_a, data_b;
    logic       rd_a, tx_a, busy_a, done_a;
    logic       rd_b, tx_b, busy_b, done_b;

    fifo_uart_tx #(.B(8), .DVSR(16), .SB(1)) u_dut_a (
        .clk(clk), .reset(reset), .empty(empty_a), .r_data(data_a),
        .rd(rd_a), .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a)
    );

    fifo_uart_tx #(.B(8), .DVSR(16), .SB(2)) u_dut_b (
        .clk(clk), .reset(reset), .empty(empty_b), .r_data(data_b),
        .rd(rd_b), .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] q[$];
    bit         sel;
    int         cyc;
    int         tog_lo = -1;
    int         tog_hi = -1;
    bit         log_rd[1024];
    bit         log_tx[1024];
    bit         log_busy[1024];
    bit         log_done[1024];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Present the FIFO head to the selected DUT; the other one sees an empty FIFO.
    task automatic drive();
        bit         tgl;
        logic       emp;
        logic [7:0] hd;
        tgl = (cyc >= tog_lo) && (cyc <= tog_hi);
        emp = (q.size() == 0) || (tgl && cyc[0]);
        hd  = (q.size() != 0) ? q[0] : 8'h00;
        if (tgl && !cyc[0]) hd = 8'($urandom);
        empty_a = sel ? 1'b1 : emp;
        data_a  = hd;
        empty_b = sel ? emp : 1'b1;
        data_b  = hd;
    endtask

    task automatic tick();
        logic       pop;
        logic [7:0] dummy;
        @(negedge clk);
        pop = sel ? rd_b : rd_a;
        if (cyc < 1024) begin
            log_rd[cyc]   = pop;
            log_tx[cyc]   = sel ? tx_b : tx_a;
            log_busy[cyc] = sel ? busy_b : busy_a;
            log_done[cyc] = sel ? done_b : done_a;
        end
        @(posedge clk);
        #1;
        if (pop && q.size() != 0) dummy = q.pop_front();
        cyc++;
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic begin_test(input bit which);
        reset  = 1'b0;
        sel    = which;
        tog_lo = -1;
        tog_hi = -1;
        q.delete();
        cyc = 0;
        for (int i = 0; i < 1024; i++) begin
            log_rd[i] = 0; log_tx[i] = 0; log_busy[i] = 0; log_done[i] = 0;
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        reset = 1'b1;
        cyc   = 0;
        drive();
    endtask

    function automatic int first_rd(input int from, input int to);
        for (int i = from; i <= to; i++) if (log_rd[i]) return i;
        return -1;
    endfunction

    function automatic int count(input int which, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) begin
            case (which)
                0:       n += int'(log_rd[i]);
                1:       n += int'(log_tx[i]);
                2:       n += int'(log_busy[i]);
                default: n += int'(log_done[i]);
            endcase
        end
        return n;
    endfunction

    // Samples each data bit in the middle of its 16-cycle period.
    function automatic logic [7:0] decode(input int s);
        logic [7:0] d;
        for (int k = 0; k < 8; k++) d[k] = log_tx[s + 1 + 16 * (k + 1) + 8];
        return d;
    endfunction

    initial begin
        logic [9:0]  exp_frame;
        logic [15:0] seg;
        int          r1, r2;

        // Reset holds everything quiet even with a word waiting.
        begin_test(0);
        q.push_back(8'h11);
        drive();
        @(negedge clk);
        check("rst_rd", int'(rd_a), 0);
        check("rst_tx", int'(tx_a), 1);
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);

        // Single 0xA5 frame.
        begin_test(0);
        q.push_back(8'hA5);
        release_rst();
        run(170);
        $display("txn single 0xA5: rd@0=%0d done@160=%0d", log_rd[0], log_done[160]);
        check("a5_rd0", int'(log_rd[0]), 1);
        check("a5_rd_cnt", count(0, 0, 169), 1);
        exp_frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 16; j++) seg[j] = log_tx[1 + 16 * k + j];
            check($sformatf("a5_bit%0d", k), int'(seg), exp_frame[k] ? 16'hFFFF : 16'h0000);
        end
        check("a5_done160", int'(log_done[160]), 1);
        check("a5_done_cnt", count(3, 0, 169), 1);
        check("a5_busy0", int'(log_busy[0]), 0);
        check("a5_busy1", int'(log_busy[1]), 1);
        check("a5_busy160", int'(log_busy[160]), 1);
        check("a5_busy161", int'(log_busy[161]), 0);
        check("a5_tx161", int'(log_tx[161]), 1);

        // Three preloaded words, back to back.
        begin_test(0);
        q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h3C);
        release_rst();
        run(500);
        r1 = first_rd(1, 499);
        r2 = (r1 >= 0) ? first_rd(r1 + 1, 499) : -1;
        $display("txn burst: rd at %0d %0d %0d", first_rd(0, 499), r1, r2);
        check("b3_rd0", first_rd(0, 499), 0);
        check("b3_rd1", r1, 161);
        check("b3_rd2", r2, 322);
        check("b3_rd_cnt", count(0, 0, 499), 3);
        check("b3_tx161", int'(log_tx[161]), 1);
        check("b3_tx322", int'(log_tx[322]), 1);
        check("b3_w0", int'(decode(0)), 8'h00);
        check("b3_w1", int'(decode(161)), 8'hFF);
        check("b3_w2", int'(decode(322)), 8'h3C);

        // Empty FIFO for 500 cycles.
        begin_test(0);
        release_rst();
        run(500);
        $display("txn idle: rd=%0d tx_ones=%0d busy=%0d", count(0, 0, 499), count(1, 0, 499), count(2, 0, 499));
        check("idle_rd", count(0, 0, 499), 0);
        check("idle_tx", count(1, 0, 499), 500);
        check("idle_busy", count(2, 0, 499), 0);

        // Reset in the middle of a 0x55 frame, then send 0x81.
        begin_test(0);
        q.push_back(8'h55);
        release_rst();
        run(70);
        @(negedge clk);
        check("abort_tx_pre", int'(tx_a), 0);
        #2;
        reset = 1'b0;
        #1;
        $display("txn abort: tx=%0d busy=%0d after async reset", tx_a, busy_a);
        check("abort_tx", int'(tx_a), 1);
        check("abort_busy", int'(busy_a), 0);
        check("abort_done", int'(done_a), 0);
        q.push_back(8'h81);
        drive();
        @(posedge clk);
        #1;
        release_rst();
        run(200);
        check("abort_rd0", int'(log_rd[0]), 1);
        check("abort_rd_cnt", count(0, 0, 199), 1);
        check("abort_word", int'(decode(0)), 8'h81);

        // Two stop bits.
        begin_test(1);
        q.push_back(8'h0F); q.push_back(8'h0F);
        release_rst();
        run(400);
        $display("txn sb2: rd at %0d %0d", first_rd(0, 399), first_rd(1, 399));
        check("sb2_rd0", first_rd(0, 399), 0);
        check("sb2_rd1", first_rd(1, 399), 177);
        check("sb2_tx144", int'(log_tx[144]), 0);
        check("sb2_stop_ones", count(1, 145, 176), 32);
        check("sb2_done160", int'(log_done[160]), 0);
        check("sb2_done176", int'(log_done[176]), 1);
        check("sb2_w0", int'(decode(0)), 8'h0F);
        check("sb2_w1", int'(decode(177)), 8'h0F);

        // empty and r_data wiggling during DATA must not disturb the frame.
        begin_test(0);
        q.push_back(8'h3C); q.push_back(8'hC3);
        tog_lo = 17;
        tog_hi = 144;
        release_rst();
        run(330);
        $display("txn toggle: rd_in_frame=%0d next_rd=%0d", count(0, 1, 160), first_rd(1, 329));
        check("tog_rd_cnt", count(0, 1, 160), 0);
        check("tog_rd161", first_rd(1, 329), 161);
        check("tog_w0", int'(decode(0)), 8'h3C);
        check("tog_w1", int'(decode(161)), 8'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
